// File: rtl/reduce_pkg.sv
// reduce_pkg: op encodings, FSM states and operand count shared by the reduction arbiter.
package reduce_pkg;
  localparam int NUM_OPERANDS = 8;
  localparam logic [1:0] OP_AND    = 2'b00;
  localparam logic [1:0] OP_OR     = 2'b01;
  localparam logic [1:0] OP_XOR    = 2'b10;
  localparam logic [1:0] OP_ANDRED = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;
  function automatic logic ident_ones(input logic [1:0] op);
    return (op == OP_AND) || (op == OP_ANDRED);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1 with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       any_grant
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] idx;
  // Walk from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    gnt_idx = '0;
    any_grant = 1'b0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        gnt_idx = idx;
        any_grant = 1'b1;
      end
    end
  end
  assign gnt = any_grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
endmodule

// File: rtl/reduce_arbiter.sv
// reduce_arbiter: round-robin scheduler sharing one 8-operand bitwise reduction datapath.
module reduce_arbiter
  import reduce_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int Port_Num = 2,
  parameter int WIDTH    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [2*NUM_REQ-1:0]                  req_op,
  input  logic [NUM_REQ*NUM_OPERANDS*WIDTH-1:0] req_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WIDTH-1:0]                      out_q,
  output logic [$clog2(NUM_REQ)-1:0]            out_id,
  output logic                                  busy
);
  localparam int IW    = $clog2(NUM_REQ);
  localparam int DW    = NUM_OPERANDS * WIDTH;
  localparam int BEATS = NUM_OPERANDS / Port_Num;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(Port_Num == 1 || Port_Num == 2 || Port_Num == 4 || Port_Num == 8)) begin : g_bad_port_num
    $error("reduce_arbiter: Port_Num must be 1, 2, 4 or 8");
  end
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("reduce_arbiter: NUM_REQ must be at least 2");
  end

  state_e            state_q;
  logic [BW-1:0]     beat_q;
  logic [1:0]        op_q;
  logic [DW-1:0]     data_q;
  logic [WIDTH-1:0]  acc_q, acc_d, opnd, res_q;
  logic [IW-1:0]     id_q, ptr_q, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic              any_grant, last_beat;
  logic [1:0]        sel_op;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .any_grant (any_grant)
  );

  assign sel_op    = req_op[2*int'(gnt_idx) +: 2];
  assign last_beat = beat_q == BW'(BEATS-1);
  assign req_ready = (rst_n && state_q == IDLE) ? gnt : '0;
  assign out_valid = state_q == HOLD;
  assign busy      = state_q != IDLE;
  assign out_q     = res_q;
  assign out_id    = id_q;

  // Fold this beat's Port_Num operands into the accumulator.
  always_comb begin
    acc_d = acc_q;
    opnd = '0;
    for (int j = 0; j < Port_Num; j++) begin
      opnd = data_q[(int'(beat_q)*Port_Num + j)*WIDTH +: WIDTH];
      acc_d = (op_q == OP_OR)  ? (acc_d | opnd) :
              (op_q == OP_XOR) ? (acc_d ^ opnd) : (acc_d & opnd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      op_q    <= OP_AND;
      data_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      id_q    <= '0;
      ptr_q   <= IW'(NUM_REQ-1);
    end else begin
      case (state_q)
        IDLE: if (any_grant) begin
          data_q  <= req_data[int'(gnt_idx)*DW +: DW];
          op_q    <= sel_op;
          acc_q   <= ident_ones(sel_op) ? '1 : '0;
          beat_q  <= '0;
          id_q    <= gnt_idx;
          ptr_q   <= gnt_idx;
          state_q <= RUN;
        end
        RUN: begin
          acc_q  <= acc_d;
          beat_q <= last_beat ? '0 : beat_q + BW'(1);
          if (last_beat) begin
            res_q   <= (op_q == OP_ANDRED) ? WIDTH'(&acc_d) : acc_d;
            state_q <= HOLD;
          end
        end
        HOLD: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reduce_arbiter.sv
// tb_reduce_arbiter: directed vectors with hand-computed results for the reduction arbiter.
module tb_reduce_arbiter;
  localparam int NR = 4;
  localparam int PN = 2;
  localparam int W  = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [2*NR-1:0]   req_op = '0;
  logic [NR*8*W-1:0] req_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_q;
  logic [1:0]        out_id;
  logic              busy;
  int n_vec = 0;
  int n_bad = 0;
  int viol = 0;

  always #5 clk = ~clk;

  reduce_arbiter #(.NUM_REQ(NR), .Port_Num(PN), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_id    (out_id),
    .busy      (busy)
  );

  always @(negedge clk)
    if (rst_n && ((busy && |req_ready) || !$onehot0(req_ready))) viol++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8*W-1:0] pack(input logic [W-1:0] a, b, c, d, e, f, g, h);
    return {h, g, f, e, d, c, b, a};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic job(input int r, input logic [1:0] op, input logic [8*W-1:0] ops, input logic [W-1:0] exp);
    int lat;
    req_op[2*r +: 2] = op;
    req_data[r*8*W +: 8*W] = ops;
    req_valid[r] = 1'b1;
    #1 chk("grant", 32'(req_ready), 32'(1 << r));
    tick;
    req_valid[r] = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk("latency", 32'(lat), 32'd5);
    chk("out_q", 32'(out_q), 32'(exp));
    chk("out_id", 32'(out_id), 32'(r));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, last, w, stable;
    repeat (3) tick;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_q", 32'(out_q), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    tick;
    job(0, 2'b00, pack(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3C), 7'h3C);
    job(1, 2'b11, pack(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F), 7'h01);
    job(2, 2'b11, pack(7'h7F, 7'h7F, 7'h7F, 7'h7E, 7'h7F, 7'h7F, 7'h7F, 7'h7F), 7'h00);
    job(0, 2'b01, pack(7'h00, 7'h00, 7'h05, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00), 7'h05);
    job(3, 2'b10, pack(7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h00), 7'h7F);
    req_valid = '1;
    out_ready = 1'b1;
    #1;
    t = 0;
    last = 0;
    for (int i = 0; i < 5; i++) begin
      w = 0;
      while (req_ready == '0 && w < 20) begin
        tick;
        t++;
        w++;
      end
      chk("rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
      if (i > 0) chk("rr_gap", 32'(t - last), 32'd6);
      last = t;
      tick;
      t++;
      chk("rr_id", 32'(out_id), 32'(i % 4));
    end
    req_valid = '0;
    w = 0;
    while (busy && w < 20) begin
      tick;
      w++;
    end
    chk("rr_drain", 32'(busy), 32'd0);
    out_ready = 1'b0;
    req_op[5:4] = 2'b00;
    req_data[2*8*W +: 8*W] = pack(7'h7F, 7'h55, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    req_valid[2] = 1'b1;
    #1 chk("hold_grant", 32'(req_ready), 32'b0100);
    tick;
    req_valid = 4'b1000;
    w = 0;
    while (!out_valid && w < 20) begin
      tick;
      w++;
    end
    stable = 0;
    repeat (10) begin
      if (out_valid && busy && out_q == 7'h55 && out_id == 2'd2 && req_ready == '0) stable++;
      tick;
    end
    chk("hold_stable", 32'(stable), 32'd10);
    chk("hold_q", 32'(out_q), 32'h55);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("post_hold_busy", 32'(busy), 32'd0);
    chk("post_hold_gnt", 32'(req_ready), 32'b1000);
    req_valid = '0;
    tick;
    req_valid[1] = 1'b1;
    tick;
    req_valid = '0;
    tick;
    tick;
    chk("run_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_q", 32'(out_q), 32'd0);
    req_valid = 4'b0101;
    #1 chk("arst_ready", 32'(req_ready), 32'd0);
    tick;
    chk("arst_no_out", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    job(0, 2'b00, pack(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F), 7'h7F);
    req_valid = '0;
    tick;
    chk("viol", 32'(viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/reduce_arbiter.md
Name: reduce_arbiter

Overview:
- Shares one 8-operand bitwise reduction datapath (the operand set a..h, reduced to a WIDTH-bit q) among NUM_REQ requesters.
- Round-robin arbiter selects a requester and latches its 8 operands and op code.
- An FSM feeds Port_Num operands per cycle into an accumulator, then holds the result on a valid/ready output port.
- Sits between operand producers and result consumers; it is the controller/scheduler for the reduction unit.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- Port_Num, 2, operands combined per cycle; must be 1, 2, 4 or 8. Any other value is an elaboration error.
- WIDTH, 8, operand/result width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester job valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  input  2*NUM_REQ  op code of requester r at [2r +: 2].
- req_data  input  NUM_REQ*8*WIDTH  operands of requester r at [r*8*WIDTH +: 8*WIDTH]; operand k (k=0 is a, k=7 is h) at [k*WIDTH +: WIDTH] within that slice.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_q  output  WIDTH  reduction result.
- out_id  output  $clog2(NUM_REQ)  index of the requester that owns out_q.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Op codes:
  - 00 AND: per-bit AND across the 8 operands.
  - 01 OR.
  - 10 XOR.
  - 11 AND-reduce: out_q = {WIDTH-1 zeros, &(all 8*WIDTH bits)}.
- Accumulator identity: all ones for ops 00 and 11; zero for ops 01 and 10.
- BEATS = 8/Port_Num.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - If any req_valid is high, the arbiter grants g: the first valid requester searching from ptr+1 upward, wrapping at NUM_REQ.
  - req_ready[g] is driven combinationally high in that cycle; that cycle is the handshake.
  - At the clock edge: latch operands and op, load the accumulator with the identity, clear beat to 0, set out_id = g, ptr = g, go to RUN.
  - No valid requester: stay in IDLE.
- RUN:
  - Each cycle, combine operands beat*Port_Num .. beat*Port_Num+Port_Num-1 into the accumulator and increment beat.
  - After the beat BEATS-1 update, go to HOLD. On the HOLD transition, out_q is registered from the accumulator (op 11 is folded to its 1-bit form here).
- HOLD:
  - out_valid = 1; out_q and out_id stay stable until out_ready = 1.
  - On handshake, go to IDLE. A new grant happens no earlier than the following cycle.
- Latency: handshake in cycle T gives out_valid = 1 from cycle T+BEATS+1 (T+5 for Port_Num=2). Minimum job spacing is BEATS+2 cycles.
- req_ready is all zero outside IDLE. req_valid/req_data changes after the handshake have no effect on the job in flight.
- Round-robin pointer:
  - Reset value is NUM_REQ-1, so requester 0 wins first.
  - Updates only on grant.
  - A requester that drops req_valid before being granted is skipped; no state is kept for it.
- Reset values: out_valid 0, out_q 0, out_id 0, busy 0, req_ready 0, state IDLE, beat 0.
- Reset mid-operation (RUN or HOLD): the job is dropped immediately (asynchronous), with no output pulse.
- out_ready high while not in HOLD is ignored.

Decomposition:
- Package reduce_pkg holds:
  - op encodings OP_AND, OP_OR, OP_XOR, OP_ANDRED
  - state enum (IDLE, RUN, HOLD)
  - NUM_OPERANDS = 8
- Sub-module rr_arbiter: combinational. Inputs are the req vector and ptr; outputs are a one-hot grant, its index, and any_grant. It is parameterised by NUM_REQ.

Test Plan (WIDTH=7, Port_Num=2, NUM_REQ=4):
1. Requester 0, op 00, operands a..g = 7'h7F, h = 7'h3C → out_q 7'h3C, out_id 0, out_valid first high exactly 5 cycles after the req_ready[0] cycle.
2. Op 11 with all operands 7'h7F → out_q 7'h01. Repeat with operand d = 7'h7E → out_q 7'h00.
3. Op 10 with operands 1, 2, 4, 8, 16, 32, 64, 0 → 7'h7F. Op 01 with all zero except c = 7'h05 → 7'h05.
4. All four req_valid held high, out_ready = 1 → grant order 0, 1, 2, 3, 0. req_ready is one-hot and high only in IDLE cycles. out_id follows the same order.
5. out_ready held low for 10 cycles in HOLD → out_valid, out_q and out_id stable, busy = 1, req_ready = 0 throughout. Releasing out_ready completes the handshake and returns the FSM to IDLE.
6. Assert rst_n = 0 during RUN beat 2 → out_valid 0 and busy 0 immediately, with no result emitted. After release with requesters 2 and 0 valid, requester 0 is granted first.
